// File: rtl/seq_multiplier_if.sv
// Handshake and operand bundle for seq_multiplier.
// master: the requester that drives Run and the operands.
// slave:  the multiplier itself.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 Run;
    logic                 Signed;
    logic [WIDTH-1:0]     Multiplicand;
    logic [WIDTH-1:0]     Multiplier;
    logic [2*WIDTH-1:0]   Product;
    logic                 Busy;
    logic                 Ready;

    modport master (
        output Run, Signed, Multiplicand, Multiplier,
        input  Product, Busy, Ready
    );

    modport slave (
        input  Run, Signed, Multiplicand, Multiplier,
        output Product, Busy, Ready
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one iteration per clock, WIDTH clocks
// from the load edge to Ready. The product register doubles as the
// multiplier shift register.
// Optional feature macro: MUL_SIGNED_EN compiles in radix-2 Booth
// (two's-complement) mode selected by Signed; without it every operation
// is unsigned and Signed is ignored.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               Reset,
    seq_multiplier_if.slave    bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [CW-1:0]        count;
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   next_product;

`ifdef MUL_SIGNED_EN
    logic                 mode;
    logic                 qm1;
`else
    logic                 unused_signed;
    assign unused_signed = bus.Signed;
`endif

    // One iteration: conditional add/subtract on the WIDTH+1-bit accumulator,
    // then shift {acc, low half} right by one. The extension bit is never
    // stored: it is 0 (unsigned) or the sign of the high half (signed), and
    // after the shift it lands back inside the product register.
    always_comb begin
        acc = {1'b0, bus.Product[2*WIDTH-1:WIDTH]};
        sum = acc;
`ifdef MUL_SIGNED_EN
        if (mode) begin
            acc = {bus.Product[2*WIDTH-1], bus.Product[2*WIDTH-1:WIDTH]};
            case ({bus.Product[0], qm1})
                2'b01:   sum = acc + {mcand[WIDTH-1], mcand};
                2'b10:   sum = acc - {mcand[WIDTH-1], mcand};
                default: sum = acc;
            endcase
        end else if (bus.Product[0]) begin
            sum = acc + {1'b0, mcand};
        end
`else
        if (bus.Product[0]) begin
            sum = acc + {1'b0, mcand};
        end
`endif
        next_product = {sum, bus.Product[WIDTH-1:1]};
    end

    // Control FSM and product register; Busy/Ready decoded from next state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            mcand       <= '0;
            count       <= '0;
            bus.Product <= '0;
            bus.Busy    <= 1'b0;
            bus.Ready   <= 1'b0;
`ifdef MUL_SIGNED_EN
            mode        <= 1'b0;
            qm1         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        mcand       <= bus.Multiplicand;
                        bus.Product <= {{WIDTH{1'b0}}, bus.Multiplier};
                        count       <= '0;
                        state       <= CALC;
                        bus.Busy    <= 1'b1;
                        bus.Ready   <= 1'b0;
`ifdef MUL_SIGNED_EN
                        mode        <= bus.Signed;
                        qm1         <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    bus.Product <= next_product;
                    count       <= count + 1'b1;
`ifdef MUL_SIGNED_EN
                    qm1         <= bus.Product[0];
`endif
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        bus.Busy  <= 1'b0;
                        bus.Ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.Run) begin
                        state     <= IDLE;
                        bus.Ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.Busy  <= 1'b0;
                    bus.Ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=32): directed corner cases
// plus randomized operations compared against plain-arithmetic products.
module tb_seq_multiplier;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic Reset;
    int   n_checks;
    int   n_pass;

    seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Exact product from the operands, signed only when the feature is built in.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
`ifdef MUL_SIGNED_EN
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
`endif
        sa = 0;
        sb = 0;
        return {32'b0, a} * {32'b0, b} + 64'(sa + sb);
    endfunction

    // One full operation: load, measure latency and Busy length, check the
    // product, then either the Run-dropped pulse or a Run-held window.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit drop, input bit scramble, input int hold,
                          output logic [63:0] result);
        logic [63:0] exp;
        int cycles;
        int busy_cnt;
        int both;
        int stable;
        exp = ref_mul(a, b, s);
        bus.Run          = 1'b1;
        bus.Multiplicand = a;
        bus.Multiplier   = b;
        bus.Signed       = s;
        @(posedge clk);
        #1;
        cycles   = 0;
        busy_cnt = int'(bus.Busy);
        both     = 0;
        while (!bus.Ready && cycles < 3 * WIDTH) begin
            if (scramble) begin
                bus.Multiplicand = $urandom;
                bus.Multiplier   = $urandom;
                bus.Signed       = 1'($urandom_range(0, 1));
            end
            if (drop && cycles == 5) bus.Run = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            if (bus.Busy) busy_cnt++;
            if (bus.Busy && bus.Ready) both++;
        end
        check({tag, " latency"}, 64'(cycles), 64'(WIDTH));
        check({tag, " busy_len"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, " busy_ready_overlap"}, 64'(both), 64'd0);
        check({tag, " product"}, bus.Product, exp);
        result = bus.Product;
        if (drop) begin
            @(posedge clk);
            #1;
            check({tag, " ready_pulse_end"}, 64'(bus.Ready), 64'd0);
        end else begin
            stable = 0;
            for (int i = 0; i < hold; i++) begin
                if (scramble) begin
                    bus.Multiplicand = $urandom;
                    bus.Multiplier   = $urandom;
                end
                @(posedge clk);
                #1;
                if (bus.Ready && !bus.Busy && bus.Product === exp) stable++;
            end
            check({tag, " held"}, 64'(stable), 64'(hold));
            bus.Run = 1'b0;
            @(posedge clk);
            #1;
            check({tag, " ready_drop"}, 64'(bus.Ready), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          seen;
        n_checks = 0;
        n_pass   = 0;
        Reset            = 1'b1;
        bus.Run          = 1'b0;
        bus.Signed       = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset product", bus.Product, 64'd0);
        check("reset busy", 64'(bus.Busy), 64'd0);
        check("reset ready", 64'(bus.Ready), 64'd0);
        Reset = 1'b0;

        run_op("3x5", 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 2, res);
        check("3x5 const", res, 64'd15);
        run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 20, res);
        check("umax const", res, 64'hFFFF_FFFE_0000_0001);
        run_op("m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0, 2, res);
`ifdef MUL_SIGNED_EN
        check("m3x7 const", res, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        check("m3x7 const", res, 64'h0000_0006_FFFF_FFEB);
`endif
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2, res);
`ifdef MUL_SIGNED_EN
        check("minxmin const", res, 64'h4000_0000_0000_0000);
`else
        check("minxmin const", res, 64'h4000_0000_0000_0000);
`endif
        run_op("drop", 32'd1234, 32'd5678, 1'b0, 1'b1, 1'b0, 0, res);
        run_op("scramble", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 3, res);

        // Reset on the 10th CALC clock with Run still high: no load, no Ready.
        bus.Run          = 1'b1;
        bus.Multiplicand = 32'd9;
        bus.Multiplier   = 32'd9;
        bus.Signed       = 1'b0;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset product", bus.Product, 64'd0);
        check("midreset busy", 64'(bus.Busy), 64'd0);
        check("midreset ready", 64'(bus.Ready), 64'd0);
        Reset   = 1'b0;
        bus.Run = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.Ready || bus.Busy) seen++;
        end
        check("midreset quiet", 64'(seen), 64'd0);
        run_op("6x7", 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 2, res);
        check("6x7 const", res, 64'd42);

        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 4 == 1) a = 32'h8000_0000;
            if (k % 5 == 2) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", k), a, b, s, ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 1) == 1), 2, res);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised iterative shift-add multiplier with a WIDTH-bit datapath and a run/ready handshake. It folds the shift-add control FSM and the product register into one block, and adds signed (radix-2 Booth) mode. It sits beside the ALU in the multiplier path and produces one exact 2·WIDTH-bit product per operation, one iteration per clock.

## Interface
- WIDTH, 32: operand width in bits; legal range ≥ 2.

- clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; one clock, synchronous reset; overrides every other input.
- Run  input  1  start request; level-sensitive, four-phase with Ready.
- Signed  input  1  mode, sampled at load: 0 = unsigned shift-add, 1 = two's-complement Booth.
- Multiplicand  input  WIDTH  operand A; sampled only at load.
- Multiplier  input  WIDTH  operand B; sampled only at load.
- Product  output  2·WIDTH  product register; valid only while Ready=1.
- Busy  output  1  high while iterating.
- Ready  output  1  high while the result is held.

## Operation
- **States:** IDLE, CALC, DONE. Reset value of every output is 0: Product=0, Busy=0, Ready=0. Internal state on reset: IDLE, counter=0, Booth bit q₋₁=0.
- **IDLE, Run=1:**
  - Latch Multiplicand to mcand and Signed to mode.
  - Product ← {WIDTH'0, Multiplier}; q₋₁ ← 0; counter ← 0.
  - Go to CALC.
- **IDLE, Run=0:** hold all registers.
- **CALC:** perform one iteration per clock on a WIDTH+1-bit accumulator acc = {ext, Product[2W-1:W]}.
  - Unsigned: if Product[0]=1, acc ← acc + {0, mcand}, where the carry lands in ext. Then shift {acc, Product[W-1:0]} right by one (logical).
  - Signed: examine {Product[0], q₋₁}.
    - 01: acc ← acc + sext(mcand).
    - 10: acc ← acc − sext(mcand).
    - 00 / 11: no add.
    - Then shift right by one (arithmetic). ext is the replicated sign. q₋₁ ← old Product[0].
  - counter increments each iteration. On the iteration with counter = WIDTH−1, go to DONE.
- **DONE:**
  - Product holds the exact product, unsigned or signed per mode.
  - Stay in DONE while Run=1; go to IDLE on the first clock with Run=0.
  - Product keeps its value until the next load.
- **Inputs ignored:** Multiplicand, Multiplier and Signed are ignored outside the load edge. Run is ignored in CALC.
- **Width rules:**
  - Counter width is $clog2(WIDTH+1).
  - The result is exact for all operand pairs, with no overflow flag needed. This includes signed −2^(W−1) × −2^(W−1) = 2^(2W−2).

## Timing
- **Load edge:** edge L, where IDLE samples Run=1. Busy=1 from L+1.
- **Iterations:** on edges L+1 … L+WIDTH. After edge L+WIDTH: Ready=1, Busy=0, Product final. Latency is exactly WIDTH clocks from the load edge to Ready, independent of operand values.
- **Busy and Ready** are registered and decoded from the next state. They are never both 1.
- **Run held high through DONE:** Ready stays 1 and no restart occurs. A new operation needs Run=0 for at least one clock, which returns to IDLE, then Run=1. Minimum issue interval is WIDTH+2 clocks.
- **Run dropped during CALC:** the computation completes. Ready is high for exactly one clock, then the block returns to IDLE.
- **Reset at any edge, including mid-CALC:** next state is IDLE, all outputs are 0, and the partial product is discarded. If Reset=1 and Run=1 on the same edge, Reset wins and no load occurs.

## Configuration
- **MUL_SIGNED_EN defined:** Booth logic and the subtract path are compiled in, and Signed selects the mode as above.
- **MUL_SIGNED_EN undefined:**
  - The Signed port remains but is ignored, and the mode is always unsigned.
  - The Booth bit and subtractor are removed.
  - Latency and handshake are unchanged.

## Test plan
- **Reset:** Reset=1 for 1 clock from an arbitrary state → Product=0, Busy=0, Ready=0, state IDLE. Then Run=1 with 3×5 → Product=15.
- **Unsigned max, WIDTH=32:** 0xFFFFFFFF × 0xFFFFFFFF, Signed=0 → Product=0xFFFFFFFE00000001. Ready rises exactly 32 clocks after the load edge, and Busy is high for 32 clocks.
- **Signed (MUL_SIGNED_EN), WIDTH=32:**
  - 0xFFFFFFFD (−3) × 7 → 0xFFFFFFFFFFFFFFEB.
  - 0x80000000 × 0x80000000 → 0x4000000000000000.
- **No macro:** same −3 × 7 operands with Signed=1 → 0x00000006FFFFFFEB, i.e. the unsigned product.
- **Reset mid-operation:** Reset asserted on the 10th CALC clock → outputs 0, no Ready pulse. A following 6 × 7 run gives 42 with full latency.
- **Handshake:**
  - Run held high after Ready → Ready stays 1 for 20 clocks and Product is stable. Run=0 → Ready=0 next clock.
  - Run dropped mid-CALC → Ready pulses for exactly 1 clock.
  - Operand inputs changed during CALC → no effect on Product.
